// File: rtl/rambus_arb_pkg.sv
// Shared types and bus widths for the two-master RAM-bus arbiter.
package rambus_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // A disabled timeout still needs a one-bit counter so the timer elaborates.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rambus_arbiter_if.sv
// Bundle of both Wishbone master ports, the shared RAM bus and the grant vector.
interface rambus_arbiter_if;
    import rambus_arb_pkg::*;

    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic              m0_ack_o;
    logic              m0_err_o;
    logic [DATA_W-1:0] m0_dat_o;

    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [DATA_W-1:0] m1_dat_i;
    logic              m1_ack_o;
    logic              m1_err_o;
    logic [DATA_W-1:0] m1_dat_o;

    logic              rambus_wb_clk_o;
    logic              rambus_wb_rst_o;
    logic              rambus_wb_cyc_o;
    logic              rambus_wb_stb_o;
    logic              rambus_wb_we_o;
    logic [SEL_W-1:0]  rambus_wb_sel_o;
    logic [ADDR_W-1:0] rambus_wb_adr_o;
    logic [DATA_W-1:0] rambus_wb_dat_o;
    logic              rambus_wb_ack_i;
    logic [DATA_W-1:0] rambus_wb_dat_i;

    logic [1:0]        grant_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_cyc_o, rambus_wb_stb_o,
        output rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o, rambus_wb_dat_o,
        input  rambus_wb_ack_i, rambus_wb_dat_i,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_cyc_o, rambus_wb_stb_o,
        input  rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o, rambus_wb_dat_o,
        output rambus_wb_ack_i, rambus_wb_dat_i,
        input  grant_o
    );

endinterface

// File: rtl/rambus_arb_timer.sv
// Saturating stall counter; expired is high while the count sits at the timeout.
module rambus_arb_timer import rambus_arb_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W   = timer_width(TIMEOUT_CYCLES);
    localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] LIMIT = ENABLED ? CNT_W'(TIMEOUT_CYCLES) : {CNT_W{1'b1}};

    logic [CNT_W-1:0] count;

    // Holding at LIMIT keeps the counter from wrapping when timeout is disabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = ENABLED && (count == LIMIT);

endmodule

// File: rtl/rambus_arbiter.sv
// Round-robin arbiter giving two Wishbone masters turns on one RAM bus, with stall timeout.
module rambus_arbiter import rambus_arb_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            wb_clk_i,
    input logic            wb_rst_i,
    rambus_arbiter_if.slave bus
);

    arb_state_t state, next_state;
    logic       last_grant;
    logic       req0, req1;
    logic       owned, own1;
    logic       expired;
    logic       timer_inc, timer_clr;

    logic              o_cyc, o_stb, o_we;
    logic [SEL_W-1:0]  o_sel;
    logic [ADDR_W-1:0] o_adr;
    logic [DATA_W-1:0] o_dat;

    assign req0  = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1  = bus.m1_cyc_i & bus.m1_stb_i;
    assign owned = (state != IDLE);
    assign own1  = (state == GRANT1);

    assign bus.rambus_wb_clk_o = wb_clk_i;
    assign bus.rambus_wb_rst_o = wb_rst_i;

    // last_grant records whoever just finished, so the other master wins the next tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (owned && (next_state == IDLE)) begin
                last_grant <= own1;
            end
        end
    end

    assign timer_clr = (state == IDLE) || bus.rambus_wb_ack_i;

    rambus_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        timer_inc  = 1'b0;

        o_cyc = own1 ? bus.m1_cyc_i : bus.m0_cyc_i;
        o_stb = own1 ? bus.m1_stb_i : bus.m0_stb_i;
        o_we  = own1 ? bus.m1_we_i  : bus.m0_we_i;
        o_sel = own1 ? bus.m1_sel_i : bus.m0_sel_i;
        o_adr = own1 ? bus.m1_adr_i : bus.m0_adr_i;
        o_dat = own1 ? bus.m1_dat_i : bus.m0_dat_i;

        bus.grant_o         = 2'b00;
        bus.rambus_wb_cyc_o = 1'b0;
        bus.rambus_wb_stb_o = 1'b0;
        bus.rambus_wb_we_o  = 1'b0;
        bus.rambus_wb_sel_o = '0;
        bus.rambus_wb_adr_o = '0;
        bus.rambus_wb_dat_o = '0;
        bus.m0_ack_o        = 1'b0;
        bus.m0_err_o        = 1'b0;
        bus.m0_dat_o        = '0;
        bus.m1_ack_o        = 1'b0;
        bus.m1_err_o        = 1'b0;
        bus.m1_dat_o        = '0;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_grant ? GRANT0 : GRANT1;
                end else if (req0) begin
                    next_state = GRANT0;
                end else if (req1) begin
                    next_state = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                timer_inc = o_stb & ~bus.rambus_wb_ack_i;
                if (!o_cyc || expired) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // On timeout the bus strobe is withdrawn and the owner sees err instead of ack.
        if (owned) begin
            bus.grant_o         = own1 ? 2'b10 : 2'b01;
            bus.rambus_wb_cyc_o = o_cyc & ~expired;
            bus.rambus_wb_stb_o = o_stb & ~expired;
            bus.rambus_wb_we_o  = o_we;
            bus.rambus_wb_sel_o = o_sel;
            bus.rambus_wb_adr_o = o_adr;
            bus.rambus_wb_dat_o = o_dat;
            if (own1) begin
                bus.m1_ack_o = bus.rambus_wb_ack_i & ~expired;
                bus.m1_err_o = expired;
                bus.m1_dat_o = bus.rambus_wb_dat_i;
            end else begin
                bus.m0_ack_o = bus.rambus_wb_ack_i & ~expired;
                bus.m0_err_o = expired;
                bus.m0_dat_o = bus.rambus_wb_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed and random checks of rambus_arbiter against a tenure-level reference model.
module tb_rambus_arbiter;

    localparam int T = 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [9:0]  m_adr [2];
    logic [31:0] m_dat [2];
    logic        ram_ack;
    logic [31:0] ram_dat;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus, who held it last, stalled cycles so far.
    bit busy;
    bit own;
    bit last;
    int stall;

    rambus_arbiter_if bus ();

    assign bus.m0_cyc_i        = m_cyc[0];
    assign bus.m0_stb_i        = m_stb[0];
    assign bus.m0_we_i         = m_we[0];
    assign bus.m0_sel_i        = m_sel[0];
    assign bus.m0_adr_i        = m_adr[0];
    assign bus.m0_dat_i        = m_dat[0];
    assign bus.m1_cyc_i        = m_cyc[1];
    assign bus.m1_stb_i        = m_stb[1];
    assign bus.m1_we_i         = m_we[1];
    assign bus.m1_sel_i        = m_sel[1];
    assign bus.m1_adr_i        = m_adr[1];
    assign bus.m1_dat_i        = m_dat[1];
    assign bus.rambus_wb_ack_i = ram_ack;
    assign bus.rambus_wb_dat_i = ram_dat;

    rambus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setM(input bit n, input logic cyc, input logic stb, input logic we,
                        input logic [3:0] sel, input logic [9:0] adr, input logic [31:0] dat);
        m_cyc[n] = cyc;
        m_stb[n] = stb;
        m_we[n]  = we;
        m_sel[n] = sel;
        m_adr[n] = adr;
        m_dat[n] = dat;
    endtask

    task automatic idleBoth();
        setM(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        setM(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    endtask

    task automatic checkOutput();
        logic        to;
        logic [1:0]  eg;
        logic [48:0] ebus;
        logic [33:0] er0, er1, resp;
        to   = busy && (stall == T);
        eg   = !busy ? 2'b00 : (own ? 2'b10 : 2'b01);
        ebus = '0;
        er0  = '0;
        er1  = '0;
        if (busy) begin
            ebus = {m_cyc[own] & ~to, m_stb[own] & ~to, m_we[own], m_sel[own], m_adr[own], m_dat[own]};
            resp = {ram_ack & ~to, to, ram_dat};
            if (own) er1 = resp;
            else     er0 = resp;
        end
        compare("grant", 64'(bus.grant_o), 64'(eg));
        compare("ram_bus", 64'({bus.rambus_wb_cyc_o, bus.rambus_wb_stb_o, bus.rambus_wb_we_o,
                                bus.rambus_wb_sel_o, bus.rambus_wb_adr_o, bus.rambus_wb_dat_o}), 64'(ebus));
        compare("m0_resp", 64'({bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o}), 64'(er0));
        compare("m1_resp", 64'({bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o}), 64'(er1));
        compare("rst_copy", 64'(bus.rambus_wb_rst_o), 64'(wb_rst_i));
    endtask

    // Advances the model by the arbitration rules using the inputs seen at the edge.
    task automatic modelUpdate();
        bit to, r0, r1;
        to = busy && (stall == T);
        r0 = m_cyc[0] && m_stb[0];
        r1 = m_cyc[1] && m_stb[1];
        if (wb_rst_i) begin
            busy = 1'b0; last = 1'b1; stall = 0;
        end else if (!busy) begin
            stall = 0;
            if (r0 && r1) begin busy = 1'b1; own = ~last; end
            else if (r0)  begin busy = 1'b1; own = 1'b0; end
            else if (r1)  begin busy = 1'b1; own = 1'b1; end
        end else if (to || !m_cyc[own]) begin
            last = own; busy = 1'b0; stall = 0;
        end else if (ram_ack) begin
            stall = 0;
        end else if (m_stb[own]) begin
            stall = (stall < T) ? stall + 1 : T;
        end
    endtask

    task automatic applyStimulus();
        #2;
        checkOutput();
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        modelUpdate();
        #1;
    endtask

    task automatic cycle();
        applyStimulus();
        tick();
    endtask

    initial begin
        idleBoth();
        ram_ack = 1'b0;
        ram_dat = 32'h0;
        busy = 1'b0; own = 1'b0; last = 1'b1; stall = 0;

        @(posedge wb_clk_i);
        #1;
        applyStimulus();
        compare("reset_grant", 64'(bus.grant_o), 64'(2'b00));
        tick();
        wb_rst_i = 1'b0;
        cycle();

        $display("[TB] single master write");
        setM(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF);
        applyStimulus();
        compare("w_idle_grant", 64'(bus.grant_o), 64'(2'b00));
        tick();
        applyStimulus();
        compare("w_grant", 64'(bus.grant_o), 64'(2'b01));
        compare("w_stb", 64'(bus.rambus_wb_stb_o), 64'(1'b1));
        tick();
        cycle();
        ram_ack = 1'b1;
        applyStimulus();
        compare("w_ack", 64'(bus.m0_ack_o), 64'(1'b1));
        compare("w_adr", 64'(bus.rambus_wb_adr_o), 64'(10'h005));
        tick();
        ram_ack = 1'b0;
        setM(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        applyStimulus();
        compare("w_ack_once", 64'(bus.m0_ack_o), 64'(1'b0));
        tick();
        cycle();

        $display("[TB] contention from reset");
        wb_rst_i = 1'b1;
        cycle();
        wb_rst_i = 1'b0;
        setM(1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 10'h010, 32'h0);
        setM(1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 10'h020, 32'hCAFEF00D);
        cycle();
        ram_ack = 1'b1;
        applyStimulus();
        compare("c_first_m0", 64'(bus.grant_o), 64'(2'b01));
        tick();
        ram_ack = 1'b0;
        setM(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        cycle();
        applyStimulus();
        compare("c_gap_idle", 64'(bus.grant_o), 64'(2'b00));
        tick();
        ram_ack = 1'b1;
        applyStimulus();
        compare("c_then_m1", 64'(bus.grant_o), 64'(2'b10));
        tick();
        ram_ack = 1'b0;
        setM(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        cycle();
        setM(1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 10'h011, 32'h0);
        setM(1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 10'h022, 32'h0);
        cycle();
        applyStimulus();
        compare("c_rr_m0_again", 64'(bus.grant_o), 64'(2'b01));
        tick();
        idleBoth();
        cycle();
        cycle();

        $display("[TB] request during foreign tenure");
        setM(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 10'h0AA, 32'h11112222);
        cycle();
        setM(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 10'h155, 32'h33334444);
        applyStimulus();
        compare("h_m1_held", 64'(bus.m1_ack_o), 64'(1'b0));
        compare("h_adr", 64'(bus.rambus_wb_adr_o), 64'(10'h0AA));
        tick();
        ram_ack = 1'b1;
        applyStimulus();
        compare("h_m1_held_ack", 64'(bus.m1_ack_o), 64'(1'b0));
        compare("h_dat", 64'(bus.rambus_wb_dat_o), 64'(32'h11112222));
        tick();
        ram_ack = 1'b0;
        setM(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        cycle();
        cycle();
        ram_ack = 1'b1;
        applyStimulus();
        compare("h_m1_served", 64'(bus.m1_ack_o), 64'(1'b1));
        tick();
        ram_ack = 1'b0;
        idleBoth();
        cycle();

        $display("[TB] stall timeout");
        setM(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h001, 32'h0);
        setM(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h002, 32'h0);
        cycle();
        for (int i = 0; i < T; i++) begin
            applyStimulus();
            compare("t_no_err_early", 64'(bus.m0_err_o), 64'(1'b0));
            tick();
        end
        applyStimulus();
        compare("t_err", 64'(bus.m0_err_o), 64'(1'b1));
        compare("t_stb_forced", 64'(bus.rambus_wb_stb_o), 64'(1'b0));
        tick();
        applyStimulus();
        compare("t_idle_after", 64'(bus.grant_o), 64'(2'b00));
        tick();
        applyStimulus();
        compare("t_m1_next", 64'(bus.grant_o), 64'(2'b10));
        tick();
        for (int i = 1; i < T; i++) cycle();
        ram_ack = 1'b1;
        applyStimulus();
        compare("t_ack_loses_ack", 64'(bus.m1_ack_o), 64'(1'b0));
        compare("t_ack_loses_err", 64'(bus.m1_err_o), 64'(1'b1));
        tick();
        ram_ack = 1'b0;
        idleBoth();
        cycle();

        $display("[TB] reset mid tenure");
        setM(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 10'h0F0, 32'h0BADC0DE);
        cycle();
        cycle();
        wb_rst_i = 1'b1;
        cycle();
        wb_rst_i = 1'b0;
        setM(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h003, 32'h0);
        applyStimulus();
        compare("r_grant", 64'(bus.grant_o), 64'(2'b00));
        compare("r_no_err", 64'(bus.m1_err_o), 64'(1'b0));
        compare("r_cyc", 64'(bus.rambus_wb_cyc_o), 64'(1'b0));
        tick();
        applyStimulus();
        compare("r_m0_first", 64'(bus.grant_o), 64'(2'b01));
        tick();
        idleBoth();
        cycle();
        cycle();

        $display("[TB] read from top address");
        setM(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h3FF, 32'h0);
        cycle();
        ram_ack = 1'b1;
        ram_dat = 32'h12345678;
        applyStimulus();
        compare("rd_m1_dat", 64'(bus.m1_dat_o), 64'(32'h12345678));
        compare("rd_m0_dat", 64'(bus.m0_dat_o), 64'(32'h0));
        tick();
        ram_ack = 1'b0;
        ram_dat = 32'h0;
        idleBoth();
        cycle();
        cycle();

        $display("[TB] random traffic");
        for (int k = 0; k < 600; k++) begin
            wb_rst_i = ($urandom_range(0, 59) == 0);
            for (int n = 0; n < 2; n++) begin
                m_cyc[n] = ($urandom_range(0, 3) != 0);
                m_stb[n] = ($urandom_range(0, 3) != 0);
                m_we[n]  = 1'($urandom);
                m_sel[n] = 4'($urandom);
                m_adr[n] = 10'($urandom);
                m_dat[n] = $urandom;
            end
            ram_ack = ($urandom_range(0, 4) == 0);
            ram_dat = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
